// File: rtl/cmp_bist_pkg.sv
// Shared definitions for the comparator BIST controller: FSM encoding and
// derived sizes of the vector space and the mismatch counter.
package cmp_bist_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEF_WIDTH = 2;
    localparam int NVEC      = 2 ** (2 * DEF_WIDTH);
    localparam int CNT_W     = 2 * DEF_WIDTH + 1;

    function automatic int nvec_of(input int width);
        return 2 ** (2 * width);
    endfunction

    function automatic int cnt_w_of(input int width);
        return 2 * width + 1;
    endfunction

endpackage

// File: rtl/cmp_bist_golden.sv
// Golden reference for the comparator under test: unsigned a > b.
module cmp_bist_golden #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt
);

    assign gt = (a > b);

endmodule

// File: rtl/cmp_bist_ctrl.sv
// Exhaustive self-checking BIST sequencer for a WIDTH-bit greater-than
// comparator: sweeps every {a,b}, compares dut_gt with the golden result.
module cmp_bist_ctrl
    import cmp_bist_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    input  logic               dut_gt,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b
);

    localparam int VEC_W = 2 * WIDTH;
    localparam int C_W   = cnt_w_of(WIDTH);
    localparam int WC_W  = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

    logic [1:0]       state_reg,  state_next;
    logic [VEC_W-1:0] vec_reg,    vec_next;
    logic [WC_W-1:0]  wait_reg,   wait_next;
    logic [C_W-1:0]   err_reg,    err_next;
    logic [WIDTH-1:0] fail_a_reg, fail_a_next;
    logic [WIDTH-1:0] fail_b_reg, fail_b_next;
    logic             first_reg,  first_next;

    logic golden_gt;
    logic sample;
    logic mismatch;

    // The vector register is the operand output register itself, so the
    // operands hold the last vector in DONE and read 0 after reset.
    assign a_out = vec_reg[VEC_W-1:WIDTH];
    assign b_out = vec_reg[WIDTH-1:0];

    cmp_bist_golden #(.WIDTH(WIDTH)) u_golden (
        .a  (a_out),
        .b  (b_out),
        .gt (golden_gt)
    );

    assign sample   = (wait_reg == WC_W'(SETTLE));
    assign mismatch = (dut_gt != golden_gt);

    always_comb begin
        state_next  = state_reg;
        vec_next    = vec_reg;
        wait_next   = wait_reg;
        err_next    = err_reg;
        fail_a_next = fail_a_reg;
        fail_b_next = fail_b_reg;
        first_next  = first_reg;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next  = ST_RUN;
                    vec_next    = '0;
                    wait_next   = '0;
                    err_next    = '0;
                    fail_a_next = '0;
                    fail_b_next = '0;
                    first_next  = 1'b0;
                end
            end
            ST_RUN: begin
                if (!sample) begin
                    wait_next = wait_reg + 1'b1;
                end else begin
                    if (mismatch) begin
                        if (err_reg != {C_W{1'b1}}) begin
                            err_next = err_reg + 1'b1;
                        end
                        if (!first_reg) begin
                            fail_a_next = a_out;
                            fail_b_next = b_out;
                            first_next  = 1'b1;
                        end
                    end
                    if (vec_reg == {VEC_W{1'b1}}) begin
                        state_next = ST_DONE;
                    end else begin
                        vec_next  = vec_reg + 1'b1;
                        wait_next = '0;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            vec_reg    <= '0;
            wait_reg   <= '0;
            err_reg    <= '0;
            fail_a_reg <= '0;
            fail_b_reg <= '0;
            first_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            vec_reg    <= vec_next;
            wait_reg   <= wait_next;
            err_reg    <= err_next;
            fail_a_reg <= fail_a_next;
            fail_b_reg <= fail_b_next;
            first_reg  <= first_next;
        end
    end

    assign busy      = (state_reg == ST_RUN);
    assign done      = (state_reg == ST_DONE);
    assign pass      = done && (err_reg == '0);
    assign err_count = err_reg;
    assign fail_a    = fail_a_reg;
    assign fail_b    = fail_b_reg;

endmodule

// File: tb/tb_cmp_bist_ctrl.sv
// Scoreboard bench for cmp_bist_ctrl: expected run results are queued when a
// run is started and checked by per-instance monitors when done rises.
module tb_cmp_bist_ctrl;

    typedef struct {
        logic [4:0] err;
        logic       pass;
        logic [1:0] fa;
        logic [1:0] fb;
        int         cycles;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start1 = 1'b0;
    logic       start0 = 1'b0;

    logic [1:0] a1, b1, fa1, fb1, a0, b0, fa0, fb0;
    logic [4:0] ec1, ec0;
    logic       busy1, done1, pass1, busy0, done0, pass0;
    logic       dut_gt1, dut_gt0, model_gt1;

    int   mode = 0;
    exp_t q1[$];
    exp_t q0[$];
    exp_t e1, e0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // Comparator stand-ins: 0 correct, 1 stuck-0, 2 stuck-1, 3 inverted.
    cmp_bist_golden #(.WIDTH(2)) u_model1 (.a(a1), .b(b1), .gt(model_gt1));
    cmp_bist_golden #(.WIDTH(2)) u_model0 (.a(a0), .b(b0), .gt(dut_gt0));

    always_comb begin
        dut_gt1 = model_gt1;
        case (mode)
            1:       dut_gt1 = 1'b0;
            2:       dut_gt1 = 1'b1;
            3:       dut_gt1 = ~model_gt1;
            default: dut_gt1 = model_gt1;
        endcase
    end

    cmp_bist_ctrl #(.WIDTH(2), .SETTLE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .a_out(a1), .b_out(b1), .dut_gt(dut_gt1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(ec1), .fail_a(fa1), .fail_b(fb1)
    );

    cmp_bist_ctrl #(.WIDTH(2), .SETTLE(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0),
        .a_out(a0), .b_out(b0), .dut_gt(dut_gt0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(ec0), .fail_a(fa0), .fail_b(fb0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor for the SETTLE=1 instance.
    int   bcnt1 = 0;
    logic dprev1 = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            bcnt1  = 0;
            dprev1 = 1'b0;
        end else begin
            if (busy1) bcnt1++;
            if (done1 && !dprev1) begin
                if (q1.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done1: got done with empty queue");
                end else begin
                    e1 = q1.pop_front();
                    $display("run1: err=%0d pass=%0d fail=(%0d,%0d) cycles=%0d", ec1, pass1, fa1, fb1, bcnt1);
                    check("run1_cycles", bcnt1, e1.cycles);
                    check("run1_err",    ec1,   e1.err);
                    check("run1_pass",   pass1, e1.pass);
                    check("run1_fail_a", fa1,   e1.fa);
                    check("run1_fail_b", fb1,   e1.fb);
                end
                bcnt1 = 0;
            end
            dprev1 = done1;
        end
    end

    // Monitor for the SETTLE=0 instance.
    int   bcnt0 = 0;
    logic dprev0 = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            bcnt0  = 0;
            dprev0 = 1'b0;
        end else begin
            if (busy0) bcnt0++;
            if (done0 && !dprev0) begin
                if (q0.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done0: got done with empty queue");
                end else begin
                    e0 = q0.pop_front();
                    $display("run0: err=%0d pass=%0d fail=(%0d,%0d) cycles=%0d", ec0, pass0, fa0, fb0, bcnt0);
                    check("run0_cycles", bcnt0, e0.cycles);
                    check("run0_err",    ec0,   e0.err);
                    check("run0_pass",   pass0, e0.pass);
                    check("run0_fail_a", fa0,   e0.fa);
                    check("run0_fail_b", fb0,   e0.fb);
                end
                bcnt0 = 0;
            end
            dprev0 = done0;
        end
    end

    task automatic pulse1();
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
    endtask

    task automatic wait_done1(input int budget);
        int k = 0;
        while (!done1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (!done1) begin
            n_err++;
            $display("FAIL wait_done1: got no done within %0d cycles", budget);
        end
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_out"},  a1,    0);
        check({tag, "_b_out"},  b1,    0);
        check({tag, "_busy"},   busy1, 0);
        check({tag, "_done"},   done1, 0);
        check({tag, "_pass"},   pass1, 0);
        check({tag, "_err"},    ec1,   0);
        check({tag, "_fail_a"}, fa1,   0);
        check({tag, "_fail_b"}, fb1,   0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, last, ndone;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        check("reset_busy0", busy0, 0);
        check("reset_done0", done0, 0);
        reset = 1'b0;

        // Correct comparator.
        mode = 0;
        q1.push_back('{5'd0, 1'b1, 2'd0, 2'd0, 32});
        pulse1();
        wait_done1(100);

        // Stuck at 0: the 6 vectors with a>b miscompare, first is a=1,b=0.
        mode = 1;
        q1.push_back('{5'd6, 1'b0, 2'd1, 2'd0, 32});
        pulse1();
        wait_done1(100);

        // Stuck at 1: the 10 vectors with a<=b miscompare, first is 0,0.
        mode = 2;
        q1.push_back('{5'd10, 1'b0, 2'd0, 2'd0, 32});
        pulse1();
        wait_done1(100);

        // Inverted: every vector miscompares.
        mode = 3;
        q1.push_back('{5'd16, 1'b0, 2'd0, 2'd0, 32});
        pulse1();
        wait_done1(100);

        // Restart straight from DONE with a correct model.
        mode = 0;
        q1.push_back('{5'd0, 1'b1, 2'd0, 2'd0, 32});
        @(negedge clk) start1 = 1'b1;
        @(posedge clk);
        #1;
        check("restart_done", done1, 0);
        check("restart_busy", busy1, 1);
        check("restart_err",  ec1,   0);
        @(negedge clk) start1 = 1'b0;
        wait_done1(100);

        // Asynchronous reset in cycle 10 of a failing run.
        mode = 3;
        pulse1();
        repeat (9) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check_all_zero("midreset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mode = 0;
        q1.push_back('{5'd0, 1'b1, 2'd0, 2'd0, 32});
        pulse1();
        wait_done1(100);

        // SETTLE=0 with start held: back-to-back 16-cycle runs, one DONE cycle each.
        repeat (3) q0.push_back('{5'd0, 1'b1, 2'd0, 2'd0, 16});
        @(negedge clk) start0 = 1'b1;
        cyc = 0;
        last = 0;
        ndone = 0;
        while (ndone < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done0) begin
                ndone++;
                if (ndone > 1) check("run0_gap", cyc - last, 17);
                last = cyc;
                if (ndone == 3) start0 = 1'b0;
            end
        end
        check("run0_done_count", ndone, 3);
        repeat (3) @(negedge clk);
        check("run0_hold_done", done0, 1);
        check("run0_hold_busy", busy0, 0);

        check("q1_drained", q1.size(), 0);
        check("q0_drained", q0.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cmp_bist_ctrl.md
Name: cmp_bist_ctrl

Overview:
- Hardware built-in self-test controller for the two-bit greater-than comparator.
- Sits on the opposite side of the comparator's interface: it generates every {a,b} operand pair on a_out/b_out, samples the comparator's gt result, checks it against a golden a>b, and reports pass/fail.
- Replaces the hand-written stimulus sequence with an exhaustive, self-checking, on-chip sequence triggered by a start pulse.

Parameters:
- WIDTH, 2, operand width in bits; vector space is 2^(2*WIDTH).
- SETTLE, 1, idle cycles after a vector is applied before dut_gt is sampled (0 allowed).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  level-sampled request to begin a test run.
- a_out  output  WIDTH  operand a driven to the comparator.
- b_out  output  WIDTH  operand b driven to the comparator.
- dut_gt  input  1  comparator result under test (1 = a>b).
- busy  output  1  run in progress.
- done  output  1  run complete; held until the next run starts.
- pass  output  1  valid while done; 1 = zero mismatches.
- err_count  output  2*WIDTH+1  mismatch count; saturates at all-ones.
- fail_a  output  WIDTH  a of the first mismatching vector.
- fail_b  output  WIDTH  b of the first mismatching vector.

Behaviour:
- Interface decision: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values: state IDLE, vec=0, wait_cnt=0. All outputs are 0: a_out, b_out, busy, done, pass, err_count, fail_a and fail_b.
- State IDLE: busy=0, done=0. If start=1 at a clock edge, go to RUN; vec, wait_cnt, err_count, fail_a, fail_b and the first-fail flag are cleared.
- State RUN: busy=1.
  - {a_out,b_out} = vec, registered, with a in the MSBs.
  - wait_cnt increments each cycle until it reaches SETTLE.
  - On the edge where wait_cnt==SETTLE, compare dut_gt against golden (a_out>b_out), unsigned.
  - On a mismatch: err_count+1, saturating. If it is the first mismatch of the run, capture fail_a/fail_b and set the first-fail flag.
  - Then, if vec is all-ones, go to DONE. Otherwise vec+1 and wait_cnt=0.
- Cycle count: each vector occupies SETTLE+1 cycles. Total run = 2^(2*WIDTH)*(SETTLE+1) cycles from the first RUN cycle; with the defaults this is 32.
- State DONE: busy=0, done=1, pass=(err_count==0). a_out/b_out hold the last vector. err_count and fail_a/fail_b are stable.
  - start=1 in DONE restarts exactly as from IDLE; done drops on the same edge.
  - There is no return to IDLE except by reset.
- start while in RUN is ignored; there is no abort input.
- Reset mid-run: the FSM returns to IDLE immediately and all outputs go to their reset values. The partial results are discarded.
- When no mismatch has occurred, fail_a/fail_b stay 0. Read them only when pass=0.
- The err_count width of 2*WIDTH+1 holds the full vector count, so saturation cannot occur for a single run; saturation logic is still required.
- dut_gt is treated as synchronous to clk. SETTLE covers combinational settling only.

Decomposition:
- Shared package cmp_bist_pkg:
  - state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2 (2'd3 is illegal and recovers to IDLE);
  - localparams NVEC=2^(2*WIDTH) and CNT_W=2*WIDTH+1.
- Sub-module cmp_bist_golden: purely combinational unsigned a>b of WIDTH bits. It is instantiated once for the expected value and is reused by the bench as its scoreboard model.

Test Plan:
- Correct comparator model, default parameters, 1-cycle start pulse -> busy high for 32 cycles; done=1, pass=1, err_count=0, fail_a=fail_b=0.
- dut_gt stuck at 0 -> err_count=6, pass=0, first fail a=1, b=0 (vec 4).
- dut_gt stuck at 1 -> err_count=10, first fail a=0, b=0.
- Inverted comparator (a<=b) -> err_count=16; then start pulsed in DONE with a correct model -> counters cleared, a fresh run of 32 cycles, pass=1.
- Reset asserted on cycle 10 of a run, asynchronously between edges -> all outputs 0 immediately, state IDLE. A following start yields a complete 32-cycle run.
- SETTLE=0, start held high throughout -> a 16-cycle run, done for one cycle, then automatic restart. Vectors are sampled the same cycle they are applied, against a correct model giving pass=1.
